// File: rtl/top_pwm.sv
// Single-channel PWM generator with start/stop strobes and programmable period/high time.
// Optional macro TOPPWM_SHADOW_RELOAD_EN reloads period/active at each period boundary while running.
module top_pwm #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] active,
  input  logic             start,
  input  logic             stop,
  output logic             pwmOut
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             start_prev_q, start_prev_d;
  logic             stop_prev_q, stop_prev_d;
  logic             pwm_out_q, pwm_out_d;
  logic             start_rise_c;
  logic             stop_rise_c;

  assign start_rise_c = start & ~start_prev_q;
  assign stop_rise_c  = stop & ~stop_prev_q;

  // Next-state, counter and output decode; output looks at the post-edge state and count.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    active_d     = active_q;
    start_prev_d = start;
    stop_prev_d  = stop;
    pwm_out_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_rise_c && !stop_rise_c) begin
          state_d  = RUN;
          period_d = period;
          active_d = active;
        end
      end
      RUN: begin
        if (stop_rise_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (period_q == '0) begin
          cnt_d = '0;
        end else if (cnt_q >= period_q - WIDTH'(1)) begin
          cnt_d = '0;
`ifdef TOPPWM_SHADOW_RELOAD_EN
          period_d = period;
          active_d = active;
`endif
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pwm_out_d = (state_d == RUN) && (period_d != '0) && (cnt_d < active_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      active_q     <= '0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      pwm_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      active_q     <= active_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      pwm_out_q    <= pwm_out_d;
    end
  end

  assign pwmOut = pwm_out_q;

endmodule

// File: tb/tb_top_pwm.sv
// Self-checking bench for top_pwm: directed scenarios plus random strobes against a cycle-count model.
module tb_top_pwm;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] period = '0;
  logic [WIDTH-1:0] active = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pwmOut;

  int tests = 0;
  int fails = 0;

  // Reference model: cycles elapsed since the start edge, folded by the latched period.
  bit m_run;
  int m_k;
  int m_per;
  int m_act;
  bit m_sprev;
  bit m_pprev;
  bit exp_pwm;

  top_pwm #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .period (period),
    .active (active),
    .start  (start),
    .stop   (stop),
    .pwmOut (pwmOut)
  );

  always #5 clk = ~clk;

  function automatic void model_edge();
    bit sr;
    bit pr;
    if (!reset) begin
      m_run = 0; m_k = 0; m_per = 0; m_act = 0;
      m_sprev = 0; m_pprev = 0; exp_pwm = 0;
      return;
    end
    sr = start && !m_sprev;
    pr = stop && !m_pprev;
    m_sprev = start;
    m_pprev = stop;
    if (!m_run) begin
      if (sr && !pr) begin
        m_run = 1; m_k = 0;
        m_per = int'(period);
        m_act = int'(active);
      end
    end else if (pr) begin
      m_run = 0;
    end else begin
      m_k++;
`ifdef TOPPWM_SHADOW_RELOAD_EN
      if (m_per != 0 && m_k == m_per) begin
        m_k = 0;
        m_per = int'(period);
        m_act = int'(active);
      end
`endif
    end
    if (m_run && m_per != 0) exp_pwm = (m_k % m_per) < m_act;
    else exp_pwm = 0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: pwmOut=%b expected %b at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, pwmOut, exp_pwm);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic count_high(input int n, input string tag, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick(tag);
      if (pwmOut === 1'b1) highs++;
    end
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1; tick(tag);
    start = 1'b0; tick(tag);
  endtask

  task automatic pulse_stop(input string tag);
    stop = 1'b1; tick(tag);
    stop = 1'b0; tick(tag);
  endtask

  initial begin
    int h1, h2, h3, h4;

    // Reset held with start asserted: stays idle.
    #2 reset = 1'b0; start = 1'b1;
    #1 check("reset_async_init", pwmOut, 1'b0);
    run(4, "reset_hold");
    start = 1'b0;
    tick("reset_hold");
    reset = 1'b1;
    run(4, "idle_after_reset");

    // 20/10 with start held six cycles: one start, 10 high / 10 low.
    period = 16'd20; active = 16'd10; start = 1'b1;
    count_high(1, "p20a10", h1);
    check_int("first_cycle_high", h1, 1);
    count_high(5, "p20a10", h2);
    start = 1'b0;
    count_high(14, "p20a10", h3);
    check_int("p20a10_highs_1", h1 + h2 + h3, 10);
    count_high(20, "p20a10", h4);
    check_int("p20a10_highs_2", h4, 10);

    pulse_stop("stop");
    run(5, "stopped");
    check("stopped_low", pwmOut, 1'b0);

    // 20/15.
    period = 16'd20; active = 16'd15; start = 1'b1;
    count_high(1, "p20a15", h1);
    start = 1'b0;
    count_high(19, "p20a15", h2);
    check_int("p20a15_highs", h1 + h2, 15);
    pulse_stop("stop");

    period = 16'd20; active = 16'd0;
    pulse_start("active0");
    run(30, "active0");
    pulse_stop("stop");

    period = 16'd20; active = 16'd20; start = 1'b1;
    count_high(1, "active_eq_period", h1);
    start = 1'b0;
    count_high(29, "active_eq_period", h2);
    check_int("active_eq_period_highs", h1 + h2, 30);
    pulse_stop("stop");

    period = 16'd0; active = 16'd5;
    pulse_start("period0");
    run(20, "period0");
    pulse_stop("stop");

    // Start and stop rise together from idle: stop wins.
    period = 16'd4; active = 16'd2;
    start = 1'b1; stop = 1'b1;
    tick("start_stop_same");
    start = 1'b0; stop = 1'b0;
    run(5, "start_stop_same");
    check("start_stop_same_low", pwmOut, 1'b0);

    // Active changes 10->5 mid-period.
    period = 16'd20; active = 16'd10; start = 1'b1;
    count_high(1, "mid_change", h1);
    start = 1'b0;
    count_high(4, "mid_change", h2);
    active = 16'd5;
    count_high(15, "mid_change", h3);
    check_int("mid_change_period1", h1 + h2 + h3, 10);
    count_high(20, "mid_change", h4);
`ifdef TOPPWM_SHADOW_RELOAD_EN
    check_int("mid_change_period2", h4, 5);
`else
    check_int("mid_change_period2", h4, 10);
`endif
    pulse_stop("stop");

    // Random strobes and parameter changes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        period = WIDTH'($urandom_range(0, 12));
        active = WIDTH'($urandom_range(0, 14));
      end
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      tick("random");
    end
    start = 1'b0; stop = 1'b0;
    pulse_stop("stop");

    // Asynchronous reset while running.
    period = 16'd10; active = 16'd10;
    pulse_start("pre_async");
    run(3, "pre_async");
    check("pre_async_high", pwmOut, 1'b1);
    reset = 1'b0;
    #1 check("async_reset", pwmOut, 1'b0);
    run(2, "in_reset");
    reset = 1'b1;
    run(4, "after_async_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
